// File: rtl/blitter_src_fetch.sv
// Blitter source fetch: walks a width x height pixel rectangle in raster order, reads bytes
// through the blitter cache and streams them through a 4-entry FIFO. Optional macro: BLIT_SRC_TRANSPARENT_EN.
module blitter_src_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [25:0] src_base,
  input  logic [15:0] src_stride,
  input  logic [11:0] width,
  input  logic [11:0] height,
`ifdef BLIT_SRC_TRANSPARENT_EN
  input  logic [8:0]  trans_key,
`endif
  output logic        busy,
  output logic        done,
  output logic [25:0] read_address,
  output logic        read_request,
  input  logic [7:0]  read_data,
  input  logic        read_stall,
  output logic [7:0]  pix_data,
  output logic        pix_we,
  output logic        pix_last,
  output logic        pix_valid,
  input  logic        pix_ready
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [25:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [25:0] row_q, row_d;
  logic [15:0] stride_q, stride_d;
  logic [11:0] width_q, width_d;
  logic [11:0] height_q, height_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        inflight_q, inflight_d;
  logic        inflight_last_q, inflight_last_d;
  logic [8:0]  fifo_q [4];
  logic [8:0]  fifo_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
`ifdef BLIT_SRC_TRANSPARENT_EN
  logic [8:0]  key_q, key_d;
`endif

  logic issue, push, pop, last_x, last_y;
  logic [3:0] occ_d;

  // A stalled cycle neither accepts the pending request nor completes the in-flight read.
  assign issue  = req_q & ~read_stall;
  assign push   = inflight_q & ~read_stall;
  assign pop    = (count_q != 3'd0) & pix_ready;
  assign last_x = (x_q == width_q - 12'd1);
  assign last_y = (y_q == height_q - 12'd1);

  always_comb begin
    state_d         = state_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    addr_d          = addr_q;
    row_d           = row_q;
    stride_d        = stride_q;
    width_d         = width_q;
    height_d        = height_q;
    x_d             = x_q;
    y_d             = y_q;
    fifo_d          = fifo_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
`ifdef BLIT_SRC_TRANSPARENT_EN
    key_d           = key_q;
`endif

    inflight_d      = issue | (inflight_q & read_stall);
    inflight_last_d = issue ? last_x : inflight_last_q;

    if (push) begin
      fifo_d[wr_ptr_q] = {inflight_last_q, read_data};
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          stride_d = src_stride;
          width_d  = width;
          height_d = height;
          addr_d   = src_base;
          row_d    = src_base;
          x_d      = 12'd0;
          y_d      = 12'd0;
          busy_d   = 1'b1;
`ifdef BLIT_SRC_TRANSPARENT_EN
          key_d    = trans_key;
`endif
          state_d  = (width == 12'd0 || height == 12'd0) ? DRAIN : FETCH;
        end
      end
      FETCH: begin
        if (issue) begin
          if (last_x) begin
            if (last_y) begin
              state_d = DRAIN;
            end else begin
              x_d    = 12'd0;
              y_d    = y_q + 12'd1;
              row_d  = row_q + {{10{stride_q[15]}}, stride_q};
              addr_d = row_q + {{10{stride_q[15]}}, stride_q};
            end
          end else begin
            x_d    = x_q + 12'd1;
            addr_d = addr_q + 26'd1;
          end
        end
      end
      DRAIN: begin
        if (count_q == 3'd0 && !inflight_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Buffered plus in-flight bytes must never exceed the FIFO depth.
    occ_d = {1'b0, count_d} + {3'b000, inflight_d};
    req_d = (state_d == FETCH) && ((req_q && read_stall) || occ_d <= 4'd3);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      addr_q          <= 26'd0;
      req_q           <= 1'b0;
      row_q           <= 26'd0;
      stride_q        <= 16'd0;
      width_q         <= 12'd0;
      height_q        <= 12'd0;
      x_q             <= 12'd0;
      y_q             <= 12'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= 9'd0;
      wr_ptr_q        <= 2'd0;
      rd_ptr_q        <= 2'd0;
      count_q         <= 3'd0;
`ifdef BLIT_SRC_TRANSPARENT_EN
      key_q           <= 9'd0;
`endif
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      addr_q          <= addr_d;
      req_q           <= req_d;
      row_q           <= row_d;
      stride_q        <= stride_d;
      width_q         <= width_d;
      height_q        <= height_d;
      x_q             <= x_d;
      y_q             <= y_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_q          <= fifo_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
`ifdef BLIT_SRC_TRANSPARENT_EN
      key_q           <= key_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign read_address = addr_q;
  assign read_request = req_q;
  assign pix_valid    = (count_q != 3'd0);
  assign pix_data     = fifo_q[rd_ptr_q][7:0];
  assign pix_last     = fifo_q[rd_ptr_q][8];
`ifdef BLIT_SRC_TRANSPARENT_EN
  assign pix_we       = ~(key_q[8] && (pix_data == key_q[7:0]));
`else
  assign pix_we       = 1'b1;
`endif

endmodule

// File: tb/tb_blitter_src_fetch.sv
// Directed bench for blitter_src_fetch: a byte-table cache model, negedge monitors that log
// issued addresses and popped pixels, and immediate-assertion checks on hand-derived values.
module tb_blitter_src_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [25:0] src_base = 26'd0;
  logic [15:0] src_stride = 16'd0;
  logic [11:0] width = 12'd0;
  logic [11:0] height = 12'd0;
  logic [8:0]  trans_key = 9'd0;
  logic        busy, done, read_request, pix_we, pix_last, pix_valid;
  logic [25:0] read_address;
  logic [7:0]  read_data, pix_data;
  logic        read_stall = 1'b0;
  logic        pix_ready = 1'b1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;

  logic [7:0]  data_mem [256];
  logic [25:0] pend_addr = 26'd0;
  logic [25:0] iss_q [$];
  int          iss_cyc_q [$];
  logic [7:0]  pix_q [$];
  logic        we_q [$];
  logic        last_q [$];

  logic        hold_prev = 1'b0;
  logic [9:0]  prev_pix = 10'd0;

  blitter_src_fetch dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .src_base     (src_base),
    .src_stride   (src_stride),
    .width        (width),
    .height       (height),
`ifdef BLIT_SRC_TRANSPARENT_EN
    .trans_key    (trans_key),
`endif
    .busy         (busy),
    .done         (done),
    .read_address (read_address),
    .read_request (read_request),
    .read_data    (read_data),
    .read_stall   (read_stall),
    .pix_data     (pix_data),
    .pix_we       (pix_we),
    .pix_last     (pix_last),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready)
  );

  // ---------------- clock / cache model ----------------
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (read_request && !read_stall) pend_addr <= read_address;
  end

  assign read_data = data_mem[pend_addr[7:0]];

  // ---------------- comparison helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (start) start_cyc = cyc;
      if (read_request && !read_stall) begin
        iss_q.push_back(read_address);
        iss_cyc_q.push_back(cyc);
      end
      if (hold_prev) check("hold_stable", {30'd0, pix_last, pix_we, pix_data}, {22'd0, prev_pix});
      hold_prev = pix_valid && !pix_ready;
      prev_pix  = {pix_last, pix_we, pix_data};
      if (pix_valid && pix_ready) begin
        pix_q.push_back(pix_data);
        we_q.push_back(pix_we);
        last_q.push_back(pix_last);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    iss_q.delete();
    iss_cyc_q.delete();
    pix_q.delete();
    we_q.delete();
    last_q.delete();
  endtask

  task automatic do_start(input logic [25:0] b, input logic [15:0] s, input logic [11:0] w,
                          input logic [11:0] h, input logic [8:0] k);
    @(posedge clock); #1;
    src_base = b; src_stride = s; width = w; height = h; trans_key = k;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1;
      if (done_cnt != d0) break;
    end
    check(tag, done_cnt - d0, 1);
    repeat (3) @(posedge clock);
    #1;
  endtask

  // Recompute the raster address walk and compare against the logs.
  task automatic check_run(input string tag, input logic [25:0] b, input logic [15:0] s,
                           input int w, input int h, input logic [8:0] k);
    logic [25:0] row, a;
    logic [7:0]  d;
    int          n;
    check({tag, "_n_iss"}, iss_q.size(), w * h);
    check({tag, "_n_pix"}, pix_q.size(), w * h);
    row = b;
    n = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        a = row + 26'(x);
        d = data_mem[a[7:0]];
        if (n < iss_q.size()) check({tag, "_addr"}, {6'd0, iss_q[n]}, {6'd0, a});
        if (n < pix_q.size()) begin
          check({tag, "_data"}, {24'd0, pix_q[n]}, {24'd0, d});
          check({tag, "_last"}, {31'd0, last_q[n]}, {31'd0, (x == w - 1)});
          check({tag, "_we"}, {31'd0, we_q[n]}, {31'd0, !(k[8] && d == k[7:0])});
        end
        n++;
      end
      row = row + {{10{s[15]}}, s};
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    for (int i = 0; i < 256; i++) data_mem[i] = 8'(i) ^ 8'h3C;
    data_mem[8'h40] = 8'hAA;
    data_mem[8'h41] = 8'h55;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", read_request, 0);
    check("rst_addr", read_address, 0);
    check("rst_valid", pix_valid, 0);

    // Scenario 1: no stall, back-to-back issue.
    clear_logs();
    d0 = done_cnt;
    do_start(26'h100, 16'd16, 12'd4, 12'd2, 9'd0);
    @(negedge clock);
    check("s1_busy", busy, 1);
    wait_done("s1_done", d0);
    check_run("s1", 26'h100, 16'd16, 4, 2, 9'd0);
    for (int i = 1; i < iss_cyc_q.size(); i++)
      check("s1_consec", iss_cyc_q[i] - iss_cyc_q[0], i);
    check("s1_busy_end", busy, 0);

    // Scenario 2: five-cycle miss stall on the first request.
    clear_logs();
    d0 = done_cnt;
    do_start(26'h100, 16'd16, 12'd4, 12'd2, 9'd0);
    read_stall = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("s2_hold_addr", read_address, 26'h100);
      check("s2_hold_req", read_request, 1);
      check("s2_no_push", pix_valid, 0);
    end
    check("s2_no_issue", iss_q.size(), 0);
    @(posedge clock); #1;
    read_stall = 1'b0;
    wait_done("s2_done", d0);
    check_run("s2", 26'h100, 16'd16, 4, 2, 9'd0);

    // Scenario 3: ten cycles of backpressure.
    clear_logs();
    d0 = done_cnt;
    do_start(26'h100, 16'd16, 12'd4, 12'd2, 9'd0);
    pix_ready = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    check("s3_buffered", iss_q.size(), 4);
    check("s3_no_pop", pix_q.size(), 0);
    check("s3_req_low", read_request, 0);
    check("s3_valid", pix_valid, 1);
    @(posedge clock); #1;
    pix_ready = 1'b1;
    wait_done("s3_done", d0);
    check_run("s3", 26'h100, 16'd16, 4, 2, 9'd0);

    // Scenario 4a: negative stride wraps modulo 2^26.
    clear_logs();
    d0 = done_cnt;
    do_start(26'h10, 16'hFFE0, 12'd2, 12'd2, 9'd0);
    wait_done("s4_done", d0);
    if (iss_q.size() > 2) check("s4_row2", {6'd0, iss_q[2]}, 32'h3FFFFF0);
    else check("s4_row2_missing", iss_q.size(), 4);
    check_run("s4", 26'h10, 16'hFFE0, 2, 2, 9'd0);

    // Scenario 4b: zero width completes without any request.
    clear_logs();
    d0 = done_cnt;
    do_start(26'h100, 16'd16, 12'd0, 12'd3, 9'd0);
    @(negedge clock);
    check("s4w0_busy", busy, 1);
    wait_done("s4w0_done", d0);
    check("s4w0_latency", done_cyc - start_cyc, 2);
    check("s4w0_no_req", iss_q.size(), 0);
    check("s4w0_no_pix", pix_q.size(), 0);

    // Scenario 5: reset at the third pixel aborts silently.
    clear_logs();
    d0 = done_cnt;
    do_start(26'h200, 16'd16, 12'd8, 12'd1, 9'd0);
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      if (pix_q.size() >= 3) break;
    end
    check("s5_reached_p3", pix_q.size() >= 3, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("s5_busy", busy, 0);
    check("s5_valid", pix_valid, 0);
    check("s5_req", read_request, 0);
    repeat (12) @(posedge clock);
    #1;
    check("s5_no_done", done_cnt, d0);
    clear_logs();
    do_start(26'h300, 16'd16, 12'd3, 12'd1, 9'd0);
    wait_done("s5_rerun_done", d0);
    check_run("s5_rerun", 26'h300, 16'd16, 3, 1, 9'd0);

`ifdef BLIT_SRC_TRANSPARENT_EN
    // Scenario 6: colour key 0xAA masks the first pixel only.
    clear_logs();
    d0 = done_cnt;
    do_start(26'h40, 16'd16, 12'd2, 12'd1, 9'h1AA);
    wait_done("s6_done", d0);
    check("s6_n_pix", pix_q.size(), 2);
    if (we_q.size() == 2) begin
      check("s6_we0", we_q[0], 0);
      check("s6_we1", we_q[1], 1);
      check("s6_pix0", pix_q[0], 8'hAA);
      check("s6_pix1", pix_q[1], 8'h55);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
